// File: rtl/otter_pkg.sv
`default_nettype none
// ============================================================================
// Package : otter_pkg
// Purpose : Shared types and constants for the execute-operand stage and the
//           ALU it feeds.
//           - alu_fun_t   : 5-bit ALU operation encoding
//           - srcA_sel_t  : ALU A-operand select (rs1 / pc / zero)
//           - srcB_sel_t  : ALU B-operand select (rs2 / imm)
//           - XLEN, REG_AW: datapath and register-address widths
// Revision: 1.0 - initial release
// ============================================================================
package otter_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_SLL  = 5'b00001,
    ALU_SLT  = 5'b00010,
    ALU_SLTU = 5'b00011,
    ALU_XOR  = 5'b00100,
    ALU_SRL  = 5'b00101,
    ALU_OR   = 5'b00110,
    ALU_AND  = 5'b00111,
    ALU_SUB  = 5'b01000,
    ALU_LUI  = 5'b01001,
    ALU_SRA  = 5'b01101
  } alu_fun_t;

  // Encoding 3 is unused and behaves like SRCA_ZERO.
  typedef enum logic [1:0] {
    SRCA_RS1  = 2'd0,
    SRCA_PC   = 2'd1,
    SRCA_ZERO = 2'd2
  } srcA_sel_t;

  typedef enum logic [0:0] {
    SRCB_RS2 = 1'b0,
    SRCB_IMM = 1'b1
  } srcB_sel_t;

endpackage : otter_pkg
`default_nettype wire

// File: rtl/ex_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Interface: ex_operand_stage_if
// Purpose  : Bundles the decode-side fields, control, bypass ports and the
//            execute-side results of the operand stage.
//            slave  : the operand stage (consumes ID/bypass, drives EX side)
//            master : the surrounding pipeline (drives ID/bypass, reads EX)
// Revision : 1.0 - initial release
// ============================================================================
interface ex_operand_stage_if;
  import otter_pkg::*;

  // decode slot
  logic              id_valid;
  logic [4:0]        id_alu_fun;
  logic [1:0]        id_srcA_sel;
  logic              id_srcB_sel;
  logic [REG_AW-1:0] id_rs1_addr;
  logic [REG_AW-1:0] id_rs2_addr;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [XLEN-1:0]   id_pc;
  logic [REG_AW-1:0] id_rd_addr;
  logic              id_reg_write;
  logic              id_mem_read;
  // pipeline control
  logic              flush;
  logic              hold;
  // bypass sources
  logic [REG_AW-1:0] exmem_rd;
  logic              exmem_wr;
  logic [XLEN-1:0]   exmem_result;
  logic [REG_AW-1:0] memwb_rd;
  logic              memwb_wr;
  logic [XLEN-1:0]   memwb_data;
  // execute side
  logic              ex_valid;
  logic [4:0]        alu_fun;
  logic [XLEN-1:0]   srcA;
  logic [XLEN-1:0]   srcB;
  logic [XLEN-1:0]   ex_rs2_fwd;
  logic [REG_AW-1:0] ex_rd_addr;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic [XLEN-1:0]   ex_pc;
  logic              stall_id;

  modport slave (
    input  id_valid, id_alu_fun, id_srcA_sel, id_srcB_sel,
           id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_pc, id_rd_addr, id_reg_write, id_mem_read,
           flush, hold,
           exmem_rd, exmem_wr, exmem_result,
           memwb_rd, memwb_wr, memwb_data,
    output ex_valid, alu_fun, srcA, srcB, ex_rs2_fwd, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_pc, stall_id
  );

  modport master (
    output id_valid, id_alu_fun, id_srcA_sel, id_srcB_sel,
           id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
           id_imm, id_pc, id_rd_addr, id_reg_write, id_mem_read,
           flush, hold,
           exmem_rd, exmem_wr, exmem_result,
           memwb_rd, memwb_wr, memwb_data,
    input  ex_valid, alu_fun, srcA, srcB, ex_rs2_fwd, ex_rd_addr,
           ex_reg_write, ex_mem_read, ex_pc, stall_id
  );

endinterface : ex_operand_stage_if
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module  : fwd_mux
// Purpose : Resolves one source operand against the EX/MEM and MEM/WB bypass
//           ports. EX/MEM is younger and wins; x0 is never bypassed.
// Ports   : i_rs_addr/i_rs_data        registered source index and data
//           i_exmem_rd/_wr/_result     EX/MEM bypass port
//           i_memwb_rd/_wr/_data       MEM/WB bypass port
//           o_fwd                      resolved operand
// Revision: 1.0 - initial release
// ============================================================================
module fwd_mux
  import otter_pkg::*;
(
  input  wire logic [REG_AW-1:0] i_rs_addr,
  input  wire logic [XLEN-1:0]   i_rs_data,
  input  wire logic [REG_AW-1:0] i_exmem_rd,
  input  wire logic              i_exmem_wr,
  input  wire logic [XLEN-1:0]   i_exmem_result,
  input  wire logic [REG_AW-1:0] i_memwb_rd,
  input  wire logic              i_memwb_wr,
  input  wire logic [XLEN-1:0]   i_memwb_data,
  output logic      [XLEN-1:0]   o_fwd
);

  logic w_rs_nonzero;
  logic w_hit_exmem;
  logic w_hit_memwb;

  assign w_rs_nonzero = (i_rs_addr != '0);
  assign w_hit_exmem  = i_exmem_wr & (i_exmem_rd == i_rs_addr) & w_rs_nonzero;
  assign w_hit_memwb  = i_memwb_wr & (i_memwb_rd == i_rs_addr) & w_rs_nonzero;

  always_comb begin
    o_fwd = i_rs_data;
    if (w_hit_exmem)
      o_fwd = i_exmem_result;
    else if (w_hit_memwb)
      o_fwd = i_memwb_data;
  end

endmodule : fwd_mux
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module  : ex_operand_stage
// Purpose : ID/EX pipeline register with operand forwarding and load-use
//           hazard detection. Drives srcA/srcB/alu_fun into the execute ALU
//           and raises stall_id to freeze IF/ID while a bubble is inserted.
// Ports   : clk    - clock, rising edge
//           rst_n  - synchronous reset, active-low
//           bus    - ex_operand_stage_if.slave: decode fields, flush/hold,
//                    EX/MEM and MEM/WB bypass ports in; EX-side operands,
//                    control and stall_id out
// Revision: 1.0 - initial release
// ============================================================================
module ex_operand_stage
  import otter_pkg::*;
#(
  parameter logic [4:0] NOP_FUN = ALU_ADD
) (
  input wire logic          clk,
  input wire logic          rst_n,
  ex_operand_stage_if.slave bus
);

  // ID/EX register
  logic              r_valid;
  logic [4:0]        r_alu_fun;
  logic [1:0]        r_srcA_sel;
  logic              r_srcB_sel;
  logic [REG_AW-1:0] r_rs1_addr;
  logic [REG_AW-1:0] r_rs2_addr;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [XLEN-1:0]   r_pc;
  logic [REG_AW-1:0] r_rd_addr;
  logic              r_reg_write;
  logic              r_mem_read;

  logic              w_ex_mem_read;
  logic              w_stall;
  logic [XLEN-1:0]   w_fwd_rs1;
  logic [XLEN-1:0]   w_fwd_rs2;

  assign w_ex_mem_read = r_valid & r_mem_read;

  // Load in EX whose destination is read by the ID instruction. rs1 only
  // matters when srcA actually uses it; rs2 always matters because it is
  // also the store-data path.
  assign w_stall = ~bus.flush & bus.id_valid & w_ex_mem_read
                 & (r_rd_addr != '0)
                 & (((r_rd_addr == bus.id_rs1_addr) & (bus.id_srcA_sel == SRCA_RS1))
                    | (r_rd_addr == bus.id_rs2_addr));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid     <= 1'b0;
      r_alu_fun   <= '0;
      r_srcA_sel  <= '0;
      r_srcB_sel  <= 1'b0;
      r_rs1_addr  <= '0;
      r_rs2_addr  <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_pc        <= '0;
      r_rd_addr   <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (bus.hold) begin
      // freeze every field
    end else if (w_stall) begin
      // Bubble; clearing valid also clears the gated mem_read, so the
      // stall cannot persist past one cycle.
      r_valid <= 1'b0;
    end else begin
      r_valid     <= bus.id_valid;
      r_alu_fun   <= bus.id_alu_fun;
      r_srcA_sel  <= bus.id_srcA_sel;
      r_srcB_sel  <= bus.id_srcB_sel;
      r_rs1_addr  <= bus.id_rs1_addr;
      r_rs2_addr  <= bus.id_rs2_addr;
      r_rs1_data  <= bus.id_rs1_data;
      r_rs2_data  <= bus.id_rs2_data;
      r_imm       <= bus.id_imm;
      r_pc        <= bus.id_pc;
      r_rd_addr   <= bus.id_rd_addr;
      r_reg_write <= bus.id_reg_write;
      r_mem_read  <= bus.id_mem_read;
    end
  end

  fwd_mux u_fwd_rs1 (
    .i_rs_addr      (r_rs1_addr),
    .i_rs_data      (r_rs1_data),
    .i_exmem_rd     (bus.exmem_rd),
    .i_exmem_wr     (bus.exmem_wr),
    .i_exmem_result (bus.exmem_result),
    .i_memwb_rd     (bus.memwb_rd),
    .i_memwb_wr     (bus.memwb_wr),
    .i_memwb_data   (bus.memwb_data),
    .o_fwd          (w_fwd_rs1)
  );

  fwd_mux u_fwd_rs2 (
    .i_rs_addr      (r_rs2_addr),
    .i_rs_data      (r_rs2_data),
    .i_exmem_rd     (bus.exmem_rd),
    .i_exmem_wr     (bus.exmem_wr),
    .i_exmem_result (bus.exmem_result),
    .i_memwb_rd     (bus.memwb_rd),
    .i_memwb_wr     (bus.memwb_wr),
    .i_memwb_data   (bus.memwb_data),
    .o_fwd          (w_fwd_rs2)
  );

  always_comb begin
    bus.srcA = '0;
    case (r_srcA_sel)
      SRCA_RS1: bus.srcA = w_fwd_rs1;
      SRCA_PC:  bus.srcA = r_pc;
      default:  bus.srcA = '0;
    endcase
  end

  assign bus.srcB         = (r_srcB_sel == SRCB_IMM) ? r_imm : w_fwd_rs2;
  assign bus.ex_rs2_fwd   = w_fwd_rs2;
  assign bus.ex_valid     = r_valid;
  assign bus.alu_fun      = r_valid ? r_alu_fun : NOP_FUN;
  assign bus.ex_rd_addr   = r_rd_addr;
  assign bus.ex_reg_write = r_valid & r_reg_write;
  assign bus.ex_mem_read  = w_ex_mem_read;
  assign bus.ex_pc        = r_pc;
  assign bus.stall_id     = w_stall;

endmodule : ex_operand_stage
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_ex_operand_stage
// Purpose : Directed self-checking bench for ex_operand_stage: reset state,
//           bypass paths and priority, x0 guard, operand selection, load-use
//           bubble, flush over stall, hold freeze and mid-hold reset.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ex_operand_stage;
  import otter_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  ex_operand_stage_if bus ();

  ex_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] fun, input logic [1:0] asel,
                        input logic bsel, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                        input logic [31:0] pc, input logic [4:0] rd, input logic rw,
                        input logic mr);
    bus.id_valid     = v;
    bus.id_alu_fun   = fun;
    bus.id_srcA_sel  = asel;
    bus.id_srcB_sel  = bsel;
    bus.id_rs1_addr  = rs1;
    bus.id_rs2_addr  = rs2;
    bus.id_rs1_data  = d1;
    bus.id_rs2_data  = d2;
    bus.id_imm       = imm;
    bus.id_pc        = pc;
    bus.id_rd_addr   = rd;
    bus.id_reg_write = rw;
    bus.id_mem_read  = mr;
  endtask

  task automatic set_byp(input logic ew, input logic [4:0] erd, input logic [31:0] er,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] md);
    bus.exmem_wr     = ew;
    bus.exmem_rd     = erd;
    bus.exmem_result = er;
    bus.memwb_wr     = mw;
    bus.memwb_rd     = mrd;
    bus.memwb_data   = md;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.flush = 1'b0;
    bus.hold  = 1'b0;
    set_id(1'b1, 5'd8, 2'd1, 1'b1, 5'd3, 5'd4, 32'h11, 32'h22, 32'h33, 32'h44, 5'd6, 1'b1, 1'b1);
    set_byp(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // ---- reset state ----
    tick();
    check_eq("rst ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check_eq("rst reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
    check_eq("rst mem_read", {31'd0, bus.ex_mem_read}, 32'd0);
    check_eq("rst alu_fun", {27'd0, bus.alu_fun}, 32'd0);
    check_eq("rst srcA", bus.srcA, 32'd0);
    check_eq("rst srcB", bus.srcB, 32'd0);
    rst_n = 1'b1;

    // ---- 1: EX/MEM bypass on rs1 ----
    set_id(1'b1, ALU_SUB, 2'd0, 1'b0, 5'd5, 5'd6, 32'h0, 32'h66, 32'h0, 32'h100, 5'd9, 1'b1, 1'b0);
    tick();
    set_byp(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0);
    #1;
    check_eq("t1 srcA exmem", bus.srcA, 32'h1234);
    check_eq("t1 srcB rf", bus.srcB, 32'h66);
    check_eq("t1 alu_fun", {27'd0, bus.alu_fun}, 32'd8);
    check_eq("t1 ex_pc", bus.ex_pc, 32'h100);
    check_eq("t1 rd", {27'd0, bus.ex_rd_addr}, 32'd9);
    check_eq("t1 reg_write", {31'd0, bus.ex_reg_write}, 32'd1);

    // ---- 2: EX/MEM beats MEM/WB ----
    set_byp(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_id(1'b1, ALU_ADD, 2'd0, 1'b0, 5'd0, 5'd7, 32'h0, 32'h77, 32'h55, 32'h104, 5'd1, 1'b1, 1'b0);
    tick();
    set_byp(1'b1, 5'd7, 32'hA, 1'b1, 5'd7, 32'hB);
    #1;
    check_eq("t2 srcB exmem wins", bus.srcB, 32'hA);
    check_eq("t2 rs2_fwd exmem", bus.ex_rs2_fwd, 32'hA);
    bus.exmem_wr = 1'b0;
    #1;
    check_eq("t2 srcB memwb", bus.srcB, 32'hB);
    bus.memwb_wr = 1'b0;
    #1;
    check_eq("t2 srcB rf", bus.srcB, 32'h77);

    // ---- 3: x0 guard, srcB imm, store data independent of srcB_sel ----
    set_id(1'b1, ALU_ADD, 2'd0, 1'b1, 5'd0, 5'd7, 32'h0, 32'h77, 32'h55, 32'h108, 5'd1, 1'b1, 1'b0);
    tick();
    set_byp(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    check_eq("t3 srcA x0", bus.srcA, 32'h0);
    check_eq("t3 srcB imm", bus.srcB, 32'h55);
    check_eq("t3 rs2_fwd", bus.ex_rs2_fwd, 32'h77);
    bus.exmem_rd = 5'd7;
    #1;
    check_eq("t3 rs2_fwd bypass under imm", bus.ex_rs2_fwd, 32'hFFFF_FFFF);
    check_eq("t3 srcB still imm", bus.srcB, 32'h55);
    set_byp(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // ---- srcA selection: pc and sel 3 ----
    set_id(1'b1, ALU_ADD, 2'd1, 1'b0, 5'd2, 5'd0, 32'h22, 32'h0, 32'h0, 32'h200, 5'd1, 1'b1, 1'b0);
    tick();
    check_eq("sel srcA pc", bus.srcA, 32'h200);
    set_id(1'b1, ALU_ADD, 2'd3, 1'b0, 5'd2, 5'd0, 32'h22, 32'h0, 32'h0, 32'h204, 5'd1, 1'b1, 1'b0);
    tick();
    check_eq("sel srcA sel3 zero", bus.srcA, 32'h0);

    // ---- 4: load-use bubble ----
    set_id(1'b1, ALU_ADD, 2'd0, 1'b1, 5'd1, 5'd0, 32'h1000, 32'h0, 32'h8, 32'h300, 5'd3, 1'b1, 1'b1);
    tick();
    set_id(1'b1, ALU_OR, 2'd0, 1'b0, 5'd4, 5'd3, 32'h40, 32'h0, 32'h0, 32'h304, 5'd8, 1'b1, 1'b0);
    #1;
    check_eq("t4 ex_mem_read", {31'd0, bus.ex_mem_read}, 32'd1);
    check_eq("t4 stall_id", {31'd0, bus.stall_id}, 32'd1);
    tick();
    check_eq("t4 bubble ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check_eq("t4 bubble alu_fun", {27'd0, bus.alu_fun}, 32'd0);
    check_eq("t4 bubble reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
    check_eq("t4 stall released", {31'd0, bus.stall_id}, 32'd0);
    tick();
    set_byp(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hDEAD);
    #1;
    check_eq("t4 consumer valid", {31'd0, bus.ex_valid}, 32'd1);
    check_eq("t4 consumer alu_fun", {27'd0, bus.alu_fun}, 32'd6);
    check_eq("t4 consumer srcB memwb", bus.srcB, 32'hDEAD);
    check_eq("t4 consumer srcA", bus.srcA, 32'h40);
    set_byp(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // ---- 5: flush overrides stall, then hold freeze ----
    set_id(1'b1, ALU_ADD, 2'd0, 1'b1, 5'd1, 5'd0, 32'h1000, 32'h0, 32'h8, 32'h400, 5'd3, 1'b1, 1'b1);
    tick();
    set_id(1'b1, ALU_OR, 2'd0, 1'b0, 5'd4, 5'd3, 32'h40, 32'h0, 32'h0, 32'h404, 5'd8, 1'b1, 1'b0);
    bus.flush = 1'b1;
    #1;
    check_eq("t5 stall masked by flush", {31'd0, bus.stall_id}, 32'd0);
    tick();
    bus.flush = 1'b0;
    check_eq("t5 flushed ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    set_id(1'b1, ALU_AND, 2'd1, 1'b0, 5'd0, 5'd5, 32'h0, 32'h50, 32'h0, 32'h500, 5'd10, 1'b1, 1'b0);
    tick();
    check_eq("t5 loaded valid", {31'd0, bus.ex_valid}, 32'd1);
    bus.hold = 1'b1;
    set_id(1'b1, ALU_SLT, 2'd0, 1'b1, 5'd9, 5'd9, 32'h9, 32'h9, 32'h9, 32'h600, 5'd11, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t5 hold alu_fun", {27'd0, bus.alu_fun}, 32'd7);
      check_eq("t5 hold srcA", bus.srcA, 32'h500);
      check_eq("t5 hold rd", {27'd0, bus.ex_rd_addr}, 32'd10);
      check_eq("t5 hold valid", {31'd0, bus.ex_valid}, 32'd1);
    end
    set_byp(1'b1, 5'd5, 32'h99, 1'b0, 5'd0, 32'h0);
    #1;
    check_eq("t5 hold live forward", bus.srcB, 32'h99);

    // ---- 6: reset during hold ----
    check_eq("t6 pre reg_write", {31'd0, bus.ex_reg_write}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("t6 ex_valid", {31'd0, bus.ex_valid}, 32'd0);
    check_eq("t6 reg_write", {31'd0, bus.ex_reg_write}, 32'd0);
    check_eq("t6 mem_read", {31'd0, bus.ex_mem_read}, 32'd0);
    check_eq("t6 srcA", bus.srcA, 32'd0);
    check_eq("t6 stall", {31'd0, bus.stall_id}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ex_operand_stage
`default_nettype wire
